// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared types and default sizes for the FIFO word packer slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DEF_IN_WIDTH = 8;
    localparam int DEF_RATIO    = 4;

    typedef enum logic [1:0] {
        S_REQ = 2'd0,
        S_CAP = 2'd1,
        S_OUT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_word_packer_if.sv
// ============================================================================
// Module   : fifo_word_packer_if
// Brief    : FIFO read port plus packed-word valid/ready stream for the packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_word_packer_if
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int RATIO    = DEF_RATIO
) ();

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;

    logic                 fifo_empty;
    logic                 fifo_re;
    logic [IN_WIDTH-1:0]  fifo_rdata;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [RATIO-1:0]     out_keep;

    // master = the packer, slave = FIFO plus downstream consumer side
    modport master (
        input  fifo_empty, fifo_rdata, flush, out_ready,
        output fifo_re, out_valid, out_data, out_keep
    );

    modport slave (
        output fifo_empty, fifo_rdata, flush, out_ready,
        input  fifo_re, out_valid, out_data, out_keep
    );

endinterface

`default_nettype wire

// File: rtl/sync_8x8_fifo.sv
// ============================================================================
// Module   : sync_8x8_fifo
// Brief    : 8-deep x 8-bit synchronous FIFO, registered read data and flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_8x8_fifo (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       we,
    input  wire logic [7:0] wdata,
    output logic            full,
    input  wire logic       re,
    output logic [7:0]      rdata,
    output logic            empty
);

    logic [7:0] mem_q [8];
    logic [2:0] wptr_q, wptr_d;
    logic [2:0] rptr_q, rptr_d;
    logic [3:0] count_q, count_d;
    logic       empty_q, full_q;
    logic [7:0] rdata_q, rdata_d;
    logic       wr_en, rd_en;

    always_comb begin
        wr_en   = we && !full_q;
        rd_en   = re && (count_q != 4'd0);
        wptr_d  = wr_en ? wptr_q + 3'd1 : wptr_q;
        rptr_d  = rd_en ? rptr_q + 3'd1 : rptr_q;
        count_d = count_q + {3'b000, wr_en} - {3'b000, rd_en};
        rdata_d = rd_en ? mem_q[rptr_q] : rdata_q;
    end

    // empty is computed from the current count, so it trails occupancy by a cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            count_q <= 4'd0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= (count_q == 4'd0);
            full_q  <= (count_d == 4'd8);
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ============================================================================
// Module   : fifo_word_packer
// Brief    : Drains bytes from a FIFO and packs RATIO of them into one word,
//            with flush-driven partial words marked by per-lane keep bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int RATIO    = DEF_RATIO
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fifo_word_packer_if.master bus
);

    localparam int                OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int                IDX_W     = $clog2(RATIO);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RATIO - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        case (state_q)
            S_REQ: begin
                // FIFO data always wins over flush, so nothing is left behind
                if (!bus.fifo_empty) begin
                    state_d = S_CAP;
                end else if (bus.flush && (idx_q != '0)) begin
                    state_d = S_OUT;
                end
            end
            S_CAP: begin
                for (int i = 0; i < RATIO; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        out_data_d[i*IN_WIDTH +: IN_WIDTH] = bus.fifo_rdata;
                        out_keep_d[i]                      = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_OUT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_data_d = '0;
                    out_keep_d = '0;
                    idx_d      = '0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            idx_q      <= '0;
            out_data_q <= '0;
            out_keep_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
        end
    end

    // A read is only ever requested from S_REQ, and S_CAP always follows, which
    // keeps reads at least one cycle apart and hides the empty-flag lag.
    assign bus.fifo_re   = (state_q == S_REQ) && !bus.fifo_empty;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================================
// Module   : tb_fifo_word_packer
// Brief    : Self-checking bench: sync_8x8_fifo feeding fifo_word_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_word_packer;
    import fifo_pkg::*;

    localparam int IW = 8;
    localparam int R  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we;
    logic [7:0] wdata;
    logic       full;

    always #5 clk = ~clk;

    fifo_word_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus ();

    sync_8x8_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .wdata (wdata),
        .full  (full),
        .re    (bus.fifo_re),
        .rdata (bus.fifo_rdata),
        .empty (bus.fifo_empty)
    );

    fifo_word_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: bytes go in order into words of R lanes, lane 0 first
    logic [7:0]  pend[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];

    function automatic void model_emit();
        logic [31:0] d = '0;
        logic [3:0]  k = '0;
        for (int i = 0; i < pend.size(); i++) begin
            d = d | (32'(pend[i]) << (8 * i));
            k[i] = 1'b1;
        end
        exp_data.push_back(d);
        exp_keep.push_back(k);
        pend.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        pend.push_back(b);
        if (pend.size() == R) model_emit();
    endfunction

    function automatic void model_flush();
        if (pend.size() > 0) model_emit();
    endfunction

    int   re_count = 0;
    logic prev_re  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.fifo_re) begin
                re_count++;
                check("re_back_to_back", prev_re, 1'b0);
            end
            prev_re = bus.fifo_re;
            if (bus.out_valid) begin
                if (exp_data.size() == 0) begin
                    check("spurious_valid", bus.out_valid, 1'b0);
                end else begin
                    check("out_data", bus.out_data, exp_data[0]);
                    check("out_keep", bus.out_keep, exp_keep[0]);
                    if (bus.out_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_keep.pop_front());
                    end
                end
            end
        end else begin
            prev_re = 1'b0;
        end
    end

    // 0: always ready, 1: stalled, 2: random
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        int t = 0;
        while (full && t < 300) begin
            tick();
            t++;
        end
        check("write_full_timeout", full, 1'b0);
        if (!full) begin
            we    = 1'b1;
            wdata = b;
            tick();
            we    = 1'b0;
            model_byte(b);
        end
    endtask

    task automatic wait_empty();
        int t = 0;
        while (!bus.fifo_empty && t < 200) begin
            tick();
            t++;
        end
        check("empty_timeout", bus.fifo_empty, 1'b1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_data.size() > 0 && t < 1000) begin
            tick();
            t++;
        end
        check("drain_timeout", exp_data.size(), 0);
    endtask

    task automatic do_flush();
        wait_empty();
        tick(4);
        bus.flush = 1'b1;
        model_flush();
        tick(3);
        bus.flush = 1'b0;
        wait_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc0;
        we        = 1'b0;
        wdata     = 8'h00;
        bus.flush = 1'b0;
        rst       = 1'b0;
        tick(3);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_keep",  bus.out_keep,  4'b0000);
        check("rst_out_data",  bus.out_data,  32'h0);
        check("rst_fifo_re",   bus.fifo_re,   1'b0);
        rst = 1'b1;
        tick(2);

        // One full word
        rc0 = re_count;
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
        wait_drain();
        tick(4);
        check("word1_re_count", re_count - rc0, 4);

        // Two words under a long stall
        ready_mode = 1;
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        tick(20);
        check("stall_valid_held", bus.out_valid, 1'b1);
        ready_mode = 0;
        wait_drain();

        // Partial word via flush
        write_byte(8'hAA); write_byte(8'hBB);
        do_flush();
        tick(10);
        check("post_flush_idle", bus.out_valid, 1'b0);

        // Flush with nothing pending does nothing
        bus.flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 0) begin
                check("idle_flush_valid", bus.out_valid, 1'b0);
                check("idle_flush_re",    bus.fifo_re,   1'b0);
            end
        end
        bus.flush = 1'b0;

        // Single last entry: exactly one read despite the empty-flag lag
        rc0 = re_count;
        write_byte(8'h5A);
        wait_empty();
        tick(6);
        check("last_entry_re_count", re_count - rc0, 1);
        do_flush();

        // Reset in the middle of a word
        write_byte(8'h71); write_byte(8'h72); write_byte(8'h73);
        wait_empty();
        tick(4);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_keep",  bus.out_keep,  4'b0000);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out_data",  bus.out_data,  32'h0);
        pend.delete();
        exp_data.delete();
        exp_keep.delete();
        tick(2);
        rst = 1'b1;
        tick(2);
        write_byte(8'hC1); write_byte(8'hC2); write_byte(8'hC3); write_byte(8'hC4);
        wait_drain();

        // Randomized traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            write_byte(8'($urandom_range(0, 255)));
            tick($urandom_range(0, 3));
        end
        wait_drain();
        ready_mode = 0;
        for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)));
        do_flush();
        tick(5);
        check("final_pending", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
